// File: rtl/activation_sequencer_pkg.sv
// Shared definitions for the activation sequencer: data geometry, FSM states,
// packed-vector indexing and the activation lookup table.
package nn_act_pkg;

   localparam int unsigned W_DATA        = 8;
   localparam int unsigned LUT_ADDR_BITS = 4;
   localparam int unsigned FRAC_BITS     = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } seq_state_e;

   function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned w);
      return i * w;
   endfunction

   // Entries are indexed by the raw top bits of z: 0..7 cover z>=0, 8..15 cover z<0.
   function automatic logic signed [W_DATA-1:0] act_lut(input logic [LUT_ADDR_BITS-1:0] addr);
      logic signed [W_DATA-1:0] v;
      case (addr)
         4'd0:    v =  8'sd0;
         4'd1:    v =  8'sd15;
         4'd2:    v =  8'sd29;
         4'd3:    v =  8'sd41;
         4'd4:    v =  8'sd51;
         4'd5:    v =  8'sd58;
         4'd6:    v =  8'sd63;
         4'd7:    v =  8'sd66;
         4'd8:    v = -8'sd68;
         4'd9:    v = -8'sd66;
         4'd10:   v = -8'sd63;
         4'd11:   v = -8'sd58;
         4'd12:   v = -8'sd51;
         4'd13:   v = -8'sd41;
         4'd14:   v = -8'sd29;
         default: v = -8'sd15;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/activation_sequencer_if.sv
// Request/result bundle between a layer and its activation sequencer.
interface activation_sequencer_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = nn_act_pkg::W_DATA
);
   logic           start;
   logic [N*W-1:0] z_vec;
   logic           busy;
   logic           done;
   logic [N*W-1:0] a_vec;

   modport master (output start, output z_vec, input busy, input done, input a_vec);
   modport slave  (input start, input z_vec, output busy, output done, output a_vec);
endinterface

// File: rtl/activation_sequencer_activation_unit.sv
// Shared activation: 16-entry LUT on the top four bits of z, linear interpolation
// towards the next entry using the low four bits as an unsigned fraction.
module activation_unit
   import nn_act_pkg::*;
(
   input  logic signed [W_DATA-1:0] z_value,
   output logic signed [W_DATA-1:0] a
);

   localparam int unsigned PW = W_DATA + FRAC_BITS + 3;

   logic [LUT_ADDR_BITS-1:0] w_addr;
   logic [LUT_ADDR_BITS-1:0] w_addr_nxt;
   logic signed [W_DATA-1:0] w_base;
   logic signed [W_DATA-1:0] w_next;
   logic signed [W_DATA:0]   w_diff;
   logic signed [PW-1:0]     w_prod;
   logic [W_DATA-1:0]        w_step;

   assign w_addr     = z_value[W_DATA-1 -: LUT_ADDR_BITS];
   // Wraps modulo 16, so entry 7 interpolates towards entry 8 and 15 towards 0.
   assign w_addr_nxt = w_addr + LUT_ADDR_BITS'(1);
   assign w_base     = act_lut(w_addr);
   assign w_next     = act_lut(w_addr_nxt);
   assign w_diff     = {w_next[W_DATA-1], w_next} - {w_base[W_DATA-1], w_base};
   assign w_prod     = PW'(w_diff) * $signed(PW'({1'b0, z_value[FRAC_BITS-1:0]}));
   assign w_step     = W_DATA'(w_prod >>> FRAC_BITS);
   assign a          = w_base + w_step;

endmodule

// File: rtl/activation_sequencer.sv
// Streams N pre-activations through one shared activation unit and publishes
// the complete activation vector atomically with a one-cycle done pulse.
module activation_sequencer
   import nn_act_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned W    = W_DATA,
   parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
   input logic                   clk,
   input logic                   rst,
   activation_sequencer_if.slave bus
);

   seq_state_e r_state;
   seq_state_e w_state_nxt;

   logic [W-1:0]    r_z_buf [N];
   logic [W-1:0]    r_w_buf [N];
   logic [IDXW-1:0] r_idx;
   logic [IDXW-1:0] r_st_idx;
   logic            r_st_vld;
   logic [W-1:0]    r_z_stage;
   logic [N*W-1:0]  r_a_vec;
   logic            r_busy;
   logic            r_done;

   logic [W-1:0]    w_act;
   logic            w_accept;
   logic            w_issue;
   logic            w_drain;

   activation_unit u_act (
      .z_value (r_z_stage),
      .a       (w_act)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_drain     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            w_issue = 1'b1;
            if (r_idx == IDXW'(N - 1)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            w_drain     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < N; i++) begin
            r_z_buf[i] <= '0;
            r_w_buf[i] <= '0;
         end
         r_idx     <= '0;
         r_st_idx  <= '0;
         r_st_vld  <= 1'b0;
         r_z_stage <= '0;
         r_a_vec   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_accept) begin
            for (int unsigned i = 0; i < N; i++)
               r_z_buf[i] <= bus.z_vec[elem_lsb(i, W) +: W];
            r_idx  <= '0;
            r_busy <= 1'b1;
         end
         if (w_issue) begin
            r_z_stage <= r_z_buf[r_idx];
            r_st_idx  <= r_idx;
            r_st_vld  <= 1'b1;
            r_idx     <= r_idx + IDXW'(1);
         end
         if (r_st_vld) r_w_buf[r_st_idx] <= w_act;
         r_done <= w_drain;
         // The last element is still in flight on the drain edge, so it is merged directly.
         if (w_drain) begin
            for (int unsigned i = 0; i < N; i++)
               r_a_vec[elem_lsb(i, W) +: W] <= (i == N - 1) ? w_act : r_w_buf[i];
            r_busy   <= 1'b0;
            r_st_vld <= 1'b0;
         end
      end
   end

   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign bus.a_vec = r_a_vec;

endmodule

// File: tb/tb_activation_sequencer.sv
// Self-checking bench: table-driven runs, hand-written corner sequences and
// randomized runs compared against an arithmetic model of the activation.
module tb_activation_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   activation_sequencer_if #(.N(4), .W(8)) bus4 ();
   activation_sequencer_if #(.N(1), .W(8)) bus1 ();

   activation_sequencer #(.N(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   activation_sequencer #(.N(1), .W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   localparam int LUT [16] = '{0, 15, 29, 41, 51, 58, 63, 66,
                               -68, -66, -63, -58, -51, -41, -29, -15};

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] z;
      logic [31:0] exp;
      bit          poke;
      string       name;
   } vec_t;

   vec_t tbl [4];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // Floor-division interpolation on raw unsigned bits of z, reduced modulo 256.
   function automatic logic [7:0] act_model(input logic [7:0] z);
      int u, addr, rem, base, nxt, d, q;
      u    = int'(z);
      addr = u / 16;
      rem  = u % 16;
      base = LUT[addr];
      nxt  = LUT[(addr + 1) % 16];
      d    = (nxt - base) * rem;
      q    = d / 16;
      if (d < 0 && (d % 16) != 0) q = q - 1;
      return 8'(base + q);
   endfunction

   function automatic logic [31:0] model_vec(input logic [31:0] z);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = act_model(z[8*i +: 8]);
      return r;
   endfunction

   // Called at the negedge where start/z_vec were driven; returns at the done
   // negedge (b2b: with the next request already driven) or one cycle later.
   task automatic wait_done(input string nm, input logic [31:0] z, input logic [31:0] exp,
                            input logic [31:0] prev_a, input bit poke, input bit b2b,
                            input logic [31:0] z_next);
      int k;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.z_vec = $urandom();
      k = 0;
      while (!bus4.done && k <= 12) begin
         check({nm, "_busy"}, 32'(bus4.busy), 32'd1);
         check({nm, "_hold"}, bus4.a_vec, prev_a);
         if (k >= 1 && k <= 4)
            check({nm, "_zstage"}, 32'(dut4.r_z_stage), 32'(z[8*(k-1) +: 8]));
         if (poke) begin
            bus4.start = 1'b1;
            bus4.z_vec = ~z;
         end
         @(negedge clk);
         k++;
      end
      bus4.start = 1'b0;
      check({nm, "_latency"}, 32'(k), 32'd5);
      check({nm, "_done"}, 32'(bus4.done), 32'd1);
      check({nm, "_busy_end"}, 32'(bus4.busy), 32'd0);
      check({nm, "_a_vec"}, bus4.a_vec, exp);
      if (b2b) begin
         bus4.start = 1'b1;
         bus4.z_vec = z_next;
      end else begin
         @(negedge clk);
         check({nm, "_pulse"}, 32'(bus4.done), 32'd0);
         check({nm, "_stable"}, bus4.a_vec, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp_a, z_cur, z_nxt;
      int          extra, k;
      bit          b2b, poke;

      bus4.start = 1'b0;
      bus4.z_vec = '0;
      bus1.start = 1'b0;
      bus1.z_vec = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus4.busy), 32'd0);
      check("rst_done", 32'(bus4.done), 32'd0);
      check("rst_a_vec", bus4.a_vec, 32'd0);
      check("rst_a_vec_n1", 32'(bus1.a_vec), 32'd0);
      rst = 1'b1;

      tbl[0] = '{32'h67452301, model_vec(32'h67452301), 1'b0, "order"};
      tbl[1] = '{32'h0F70807F, 32'h0E42BCC4,             1'b0, "boundary"};
      tbl[2] = '{32'h7F108000, model_vec(32'h7F108000), 1'b1, "poke"};
      tbl[3] = '{32'hA5C3E1F0, model_vec(32'hA5C3E1F0), 1'b1, "poke2"};

      exp_a = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus4.start = 1'b1;
         bus4.z_vec = tbl[i].z;
         wait_done(tbl[i].name, tbl[i].z, tbl[i].exp, exp_a, tbl[i].poke, 1'b0, '0);
         exp_a = tbl[i].exp;
         if (tbl[i].poke) begin
            extra = 0;
            repeat (8) begin
               @(negedge clk);
               if (bus4.done) extra++;
            end
            check({tbl[i].name, "_no_requeue"}, 32'(extra), 32'd0);
         end
      end

      // Reset on E2 abandons the run.
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.z_vec = 32'h7F108000;
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(bus4.busy), 32'd0);
      check("midrst_a_vec", bus4.a_vec, 32'd0);
      check("midrst_done", 32'(bus4.done), 32'd0);
      rst = 1'b1;
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus4.done) extra++;
      end
      check("midrst_no_done", 32'(extra), 32'd0);
      exp_a = '0;
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.z_vec = 32'h7F108000;
      wait_done("rerun", 32'h7F108000, model_vec(32'h7F108000), exp_a, 1'b0, 1'b0, '0);
      exp_a = model_vec(32'h7F108000);

      // Back-to-back: new request accepted in the done cycle.
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.z_vec = 32'h3C1E5A96;
      wait_done("b2b_first", 32'h3C1E5A96, model_vec(32'h3C1E5A96), exp_a, 1'b0, 1'b1, 32'hFFFFFFFF);
      exp_a = model_vec(32'h3C1E5A96);
      wait_done("b2b_second", 32'hFFFFFFFF, model_vec(32'hFFFFFFFF), exp_a, 1'b0, 1'b0, '0);
      exp_a = model_vec(32'hFFFFFFFF);

      // Single-neuron instance.
      @(negedge clk);
      bus1.start = 1'b1;
      bus1.z_vec = 8'h8F;
      @(negedge clk);
      bus1.start = 1'b0;
      bus1.z_vec = 8'h00;
      k = 0;
      while (!bus1.done && k <= 8) begin
         if (k == 1) check("n1_zstage", 32'(dut1.r_z_stage), 32'h8F);
         @(negedge clk);
         k++;
      end
      check("n1_latency", 32'(k), 32'd2);
      check("n1_a_vec", 32'(bus1.a_vec), 32'(act_model(8'h8F)));

      // Randomized runs with random pokes and back-to-back chaining.
      z_cur = $urandom();
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.z_vec = z_cur;
      for (int i = 0; i < 25; i++) begin
         b2b   = (i < 24) && ($urandom_range(0, 1) == 1);
         poke  = ($urandom_range(0, 1) == 1);
         z_nxt = $urandom();
         wait_done("rand", z_cur, model_vec(z_cur), exp_a, poke, b2b, z_nxt);
         exp_a = model_vec(z_cur);
         if (!b2b && i < 24) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus4.start = 1'b1;
            bus4.z_vec = z_nxt;
         end
         z_cur = z_nxt;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
